// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
//
// The block turns the PC redirect stream into in-order instruction memory
// requests. Returned words are buffered in a DEPTH-entry FIFO for decode.
// It tracks up to DEPTH outstanding requests. After a redirect it discards
// responses to requests that were issued before the redirect.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a redirect to a target that is not word aligned enters the
//   FAULT state. It also queues one fault entry {32'h13, redirect_pc, 1}.
//   When undefined, redirect_pc[1:0] is forced to zero and dec_fault is
//   always 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   en                          fetch enable (gates new requests only)
//   redirect_valid/redirect_pc  replace the fetch stream
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_rsp_valid/data         in-order responses, always accepted
//   dec_valid/ready             FIFO head handshake to decode
//   dec_instr/pc/fault          FIFO head contents
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_fault
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {FETCH, FAULT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] credit;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    state_t        state;

    logic [31:0]   tgt_pc;
    logic          tgt_fault;
    logic          req_fire;
    logic          push;
    logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt_pc    = redirect_pc;
    assign tgt_fault = |redirect_pc[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^redirect_pc[1:0];
    assign tgt_pc    = {redirect_pc[31:2], 2'b00};
    assign tgt_fault = 1'b0;
`endif

    // Credit check: every outstanding request already has a FIFO slot
    // reserved, so a response never finds the FIFO full.
    // Gating with rst_n keeps the request line low while reset is asserted.
    assign credit         = inflight + count;
    assign imem_req_valid = rst_n && (state == FETCH) && en && !redirect_valid
                            && (credit < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A redirect flushes the FIFO. Any push or pop in the same cycle is lost.
    assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = dec_valid && dec_ready && !redirect_valid;

    assign dec_valid = (count != '0);
    assign dec_instr = mem[rd_ptr].instr;
    assign dec_pc    = mem[rd_ptr].pc;
    assign dec_fault = mem[rd_ptr].fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (redirect_valid) begin
            // Every request still outstanding belongs to the old stream.
            // A response arriving in this cycle is discarded here, so it is
            // not counted in drop_cnt.
            inflight <= inflight - CW'(imem_rsp_valid);
            drop_cnt <= inflight - CW'(imem_rsp_valid);
            fetch_pc <= tgt_pc;
            resp_pc  <= tgt_pc;
            rd_ptr   <= '0;
            if (tgt_fault) begin
                state  <= FAULT;
                mem[0] <= '{instr: 32'h0000_0013, pc: tgt_pc, fault: 1'b1};
                wr_ptr <= AW'(1);
                count  <= CW'(1);
            end else begin
                state  <= FETCH;
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                mem[wr_ptr] <= '{instr: imem_rsp_data, pc: resp_pc, fault: 1'b0};
                wr_ptr      <= wr_ptr + AW'(1);
                resp_pc     <= resp_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// A memory model with programmable latency answers requests in order.
// Each accepted request pushes its expected decode entry into a scoreboard.
// A redirect clears the scoreboard. Decode pops are compared in order.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_fault(dec_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic fault; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    int          first_req_cyc = -1;
    int          first_dec_cyc = -1;
    logic        want_first = 1'b0;
    logic [31:0] first_pc_after = '0;
    logic [31:0] model_pc = 32'h0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The memory model and the scoreboard run on the falling edge. Anything
    // driven here is seen by the DUT on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            imem_rsp_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mdata(mq[0].addr);
                void'(mq.pop_front());
            end
            if (dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
            if (redirect_valid) begin
                exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                model_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00)
                    exp_q.push_back('{32'h0000_0013, redirect_pc, 1'b1});
`else
                model_pc = {redirect_pc[31:2], 2'b00};
`endif
            end else if (dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_pop", 32'(dec_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_instr", dec_instr, e.instr);
                    chk("dec_fault", 32'(dec_fault), 32'(e.fault));
                end
                pop_cnt++;
                if (want_first) begin
                    first_pc_after = dec_pc;
                    want_first     = 1'b0;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                mq.push_back('{model_pc, cyc + lat});
                exp_q.push_back('{mdata(model_pc), model_pc, 1'b0});
                req_log.push_back(imem_req_addr);
                model_pc = model_pc + 32'd4;
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        en        = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0 && exp_q.size() == 0 && !dec_valid) break;
            step(1);
        end
        chk(tag, 32'(mq.size() + exp_q.size()) + 32'(dec_valid), 32'd0);
    endtask

    task automatic wait_mq(input string tag, input int n);
        for (int i = 0; i < 50; i++) begin
            if (mq.size() == n) break;
            step(1);
        end
        chk(tag, 32'(mq.size()), 32'(n));
    endtask

    initial begin
        int r0;
        int p0;
        int idx;
        int rel;
        // Reset state, with en asserted to show that reset still blocks requests.
        en             = 1'b1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        step(3);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_fault", 32'(dec_fault), 32'd0);

        // Streaming with a 1-cycle memory.
        rst_n = 1'b1;
        rel   = cyc;
        step(12);
        chk("first_req_cyc", 32'(first_req_cyc), 32'(rel));
        chk("req_to_dec_lat", 32'(first_dec_cyc - first_req_cyc), 32'd2);
        chk("req0", req_log[0], 32'h0);
        chk("req1", req_log[1], 32'h4);
        chk("req2", req_log[2], 32'h8);
        chk("req3", req_log[3], 32'hC);
        drain("drain_stream");

        // With decode stalled, credits limit the block to DEPTH requests.
        dec_ready = 1'b0;
        en        = 1'b1;
        r0        = req_cnt;
        step(12);
        chk("stall_reqs", 32'(req_cnt - r0), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        r0        = req_cnt;
        dec_ready = 1'b1;
        step(1);
        dec_ready = 1'b0;
        step(8);
        chk("pop_one_req", 32'(req_cnt - r0), 32'd1);
        drain("drain_stall");

        // Redirect while three requests are outstanding.
        lat       = 4;
        en        = 1'b1;
        dec_ready = 1'b1;
        wait_mq("wait3", 3);
        want_first = 1'b1;
        redirect(32'h0000_0200);
        step(20);
        chk("redir_first_pc", first_pc_after, 32'h0000_0200);

        // A redirect in the same cycle as a response, followed by a second
        // back-to-back redirect.
        for (int i = 0; i < 50; i++) begin
            if (mq.size() > 0 && mq[0].due == cyc) break;
            step(1);
        end
        chk("coincide_wait", 32'(mq.size() > 0 && mq[0].due == cyc), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(1);
        redirect_pc    = 32'h0000_0500;
        want_first     = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        step(20);
        chk("b2b_first_pc", first_pc_after, 32'h0000_0500);
        drain("drain_redir");

        // Dropping en with two requests outstanding.
        en = 1'b1;
        wait_mq("wait2", 2);
        en = 1'b0;
        r0 = req_cnt;
        p0 = pop_cnt;
        step(12);
        chk("en0_reqs", 32'(req_cnt - r0), 32'd0);
        chk("en0_pops", 32'(pop_cnt - p0), 32'd2);

        // The fetch address wraps from 0xFFFF_FFFC to 0.
        lat = 1;
        idx = req_log.size();
        en  = 1'b1;
        redirect(32'hFFFF_FFF8);
        step(6);
        chk("wrap_count", 32'(req_log.size() >= idx + 3), 32'd1);
        if (req_log.size() >= idx + 3) begin
            chk("wrap0", req_log[idx],     32'hFFFF_FFF8);
            chk("wrap1", req_log[idx + 1], 32'hFFFF_FFFC);
            chk("wrap2", req_log[idx + 2], 32'h0000_0000);
        end
        drain("drain_wrap");

`ifdef FETCH_ALIGN_CHECK_EN
        // A misaligned redirect produces a single fault entry and no requests.
        dec_ready = 1'b0;
        en        = 1'b1;
        redirect(32'h0000_0102);
        chk("flt_valid", 32'(dec_valid), 32'd1);
        chk("flt_fault", 32'(dec_fault), 32'd1);
        chk("flt_pc", dec_pc, 32'h0000_0102);
        chk("flt_instr", dec_instr, 32'h0000_0013);
        r0 = req_cnt;
        step(5);
        chk("flt_no_reqs", 32'(req_cnt - r0), 32'd0);
        want_first = 1'b1;
        redirect(32'h0000_0300);
        dec_ready = 1'b1;
        step(6);
        chk("flt_exit_pc", first_pc_after, 32'h0000_0300);
        drain("drain_fault");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
